// File: rtl/sat_pkg.sv
// Shared literal layout and sequencer state encoding for the clause evaluation path.
// Literal slot layout, MSB first: {used, neg, var_idx[VW-1:0]}.
package sat_pkg;

    localparam int unsigned LIT_VW = 4;

    // Struct view at the default index width; other widths use the offset helpers.
    typedef struct packed {
        logic              used;
        logic              neg;
        logic [LIT_VW-1:0] var_idx;
    } lit_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    function automatic int unsigned lit_width(input int unsigned vw);
        return vw + 2;
    endfunction

    function automatic int unsigned used_off(input int unsigned vw);
        return vw + 1;
    endfunction

    function automatic int unsigned neg_off(input int unsigned vw);
        return vw;
    endfunction

endpackage

// File: rtl/clause_eval.sv
// Combinational clause check: unsat is 1 when no used literal of the word is true.
module clause_eval
    import sat_pkg::*;
#(
    parameter int unsigned NUM_VARS = 16,
    parameter int unsigned MAX_LITS = 4,
    parameter int unsigned VW       = $clog2(NUM_VARS)
) (
    input  logic [MAX_LITS*(VW+2)-1:0] clause_word,
    input  logic [NUM_VARS-1:0]        assignment,
    output logic                       unsat
);

    localparam int unsigned LW       = lit_width(VW);
    localparam int unsigned USED_BIT = used_off(VW);
    localparam int unsigned NEG_BIT  = neg_off(VW);

    logic [MAX_LITS-1:0] lit_true;
    logic [LW-1:0]       slot;
    logic [VW-1:0]       idx;

    // Out-of-range variable indices make the literal false.
    always_comb begin
        lit_true = '0;
        slot     = '0;
        idx      = '0;
        for (int unsigned j = 0; j < MAX_LITS; j++) begin
            slot        = clause_word[j*LW +: LW];
            idx         = slot[VW-1:0];
            lit_true[j] = slot[USED_BIT] && (32'(idx) < NUM_VARS) &&
                          (assignment[idx] ^ slot[NEG_BIT]);
        end
    end

    assign unsat = ~|lit_true;

endmodule

// File: rtl/clause_stream_evaluator.sv
// Walks the clause ROM against a latched assignment, reporting one unsat flag per cycle
// two cycles after each address; pulses sticky_clear at pass start and done at the end.
module clause_stream_evaluator
    import sat_pkg::*;
#(
    parameter  int unsigned NUM_VARS    = 16,
    parameter  int unsigned MAX_LITS    = 4,
    parameter  int unsigned NUM_CLAUSES = 32,
    localparam int unsigned VW          = $clog2(NUM_VARS),
    localparam int unsigned AW          = $clog2(NUM_CLAUSES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [AW:0]                num_clauses,
    input  logic [NUM_VARS-1:0]        assignment,
    output logic [AW-1:0]              clause_addr,
    output logic                       clause_rd,
    input  logic [MAX_LITS*(VW+2)-1:0] clause_data,
    output logic                       clause_valid,
    output logic                       clause_unsat,
    output logic [AW-1:0]              clause_idx,
    output logic                       sticky_clear,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned CW    = AW + 1;
    localparam logic [CW-1:0] MAX_N = CW'(NUM_CLAUSES);

    state_t              state;
    logic [NUM_VARS-1:0] assignment_q;
    logic [CW-1:0]       n_q;
    logic                rd_d1;
    logic [AW-1:0]       idx_d1;
    logic                unsat_comb;
    logic                last_issue;

    assign last_issue = ({1'b0, clause_addr} == n_q - 1'b1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            assignment_q <= '0;
            n_q          <= '0;
            clause_addr  <= '0;
            clause_rd    <= 1'b0;
            sticky_clear <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            sticky_clear <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        assignment_q <= assignment;
                        n_q          <= (num_clauses > MAX_N) ? MAX_N : num_clauses;
                        clause_addr  <= '0;
                        sticky_clear <= 1'b1;
                        if (num_clauses != '0) begin
                            state     <= RUN;
                            clause_rd <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (last_issue) begin
                        state     <= DRAIN;
                        clause_rd <= 1'b0;
                    end else begin
                        clause_addr <= clause_addr + 1'b1;
                    end
                end
                // Final result is on the outputs once nothing remains in the read stage.
                DRAIN: begin
                    if (clause_valid && !rd_d1) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    clause_eval #(
        .NUM_VARS (NUM_VARS),
        .MAX_LITS (MAX_LITS),
        .VW       (VW)
    ) u_eval (
        .clause_word (clause_data),
        .assignment  (assignment_q),
        .unsat       (unsat_comb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_d1        <= 1'b0;
            idx_d1       <= '0;
            clause_valid <= 1'b0;
            clause_unsat <= 1'b0;
            clause_idx   <= '0;
        end else begin
            rd_d1        <= clause_rd;
            idx_d1       <= clause_addr;
            clause_valid <= rd_d1;
            clause_unsat <= rd_d1 & unsat_comb;
            if (rd_d1) begin
                clause_idx <= idx_d1;
            end
        end
    end

endmodule

// File: tb/tb_clause_stream_evaluator.sv
// Bench for clause_stream_evaluator: pass-level reference model checked every cycle,
// plus directed passes with hand-computed results.
module tb_clause_stream_evaluator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  num_clauses;
    logic [15:0] assignment;
    logic [4:0]  clause_addr;
    logic        clause_rd;
    logic [23:0] clause_data;
    logic        clause_valid;
    logic        clause_unsat;
    logic [4:0]  clause_idx;
    logic        sticky_clear;
    logic        busy;
    logic        done;

    clause_stream_evaluator #(
        .NUM_VARS    (16),
        .MAX_LITS    (4),
        .NUM_CLAUSES (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_clauses  (num_clauses),
        .assignment   (assignment),
        .clause_addr  (clause_addr),
        .clause_rd    (clause_rd),
        .clause_data  (clause_data),
        .clause_valid (clause_valid),
        .clause_unsat (clause_unsat),
        .clause_idx   (clause_idx),
        .sticky_clear (sticky_clear),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    logic [23:0] rom [32];

    // External clause memory with one-cycle synchronous read.
    always @(posedge clk) begin
        if (clause_rd) clause_data <= rom[clause_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] lit(input bit neg, input int v);
        logic [3:0] vi;
        vi = v[3:0];
        return {1'b1, neg, vi};
    endfunction

    function automatic bit m_unsat(input logic [23:0] w, input logic [15:0] a);
        for (int j = 0; j < 4; j++) begin
            logic [5:0] s;
            s = w[j*6 +: 6];
            if (s[5] && int'(s[3:0]) < 16 && (a[s[3:0]] ^ s[4])) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Pass-level model: m_cyc is the cycle number within the current pass.
    int          tcyc = 0;
    bit          m_active = 1'b0;
    int          m_cyc = 0;
    int          m_n = 0;
    int          m_end = 0;
    logic [15:0] m_assign = '0;
    bit          sticky = 1'b0;

    initial begin
        forever begin
            bit was;
            @(posedge clk or posedge reset);
            if (reset) begin
                m_active = 1'b0;
                sticky   = 1'b0;
            end else begin
                tcyc++;
                if (sticky_clear) sticky = 1'b0;
                else if (clause_valid && clause_unsat) sticky = 1'b1;
                was = m_active;
                if (m_active) begin
                    if (m_cyc == m_end) m_active = 1'b0;
                    else m_cyc++;
                end
                if (!was && start) begin
                    m_active = 1'b1;
                    m_cyc    = 1;
                    m_n      = (int'(num_clauses) > 32) ? 32 : int'(num_clauses);
                    m_end    = (m_n == 0) ? 1 : m_n + 3;
                    m_assign = assignment;
                end
            end
        end
    end

    int   valid_cnt, rd_cnt, done_cnt, start_tc, fv_rel, sc_rel, done_rel;
    bit   seen_done;
    bit   q_unsat[$];
    int   q_idx[$];

    task automatic clear_mon();
        valid_cnt = 0; rd_cnt = 0; done_cnt = 0;
        fv_rel = -1; sc_rel = -1; done_rel = -1;
        seen_done = 1'b0;
        q_unsat.delete();
        q_idx.delete();
    endtask

    initial begin
        forever begin
            bit exp_v, exp_rd, exp_u;
            int rel;
            @(negedge clk);
            exp_v  = m_active && m_n > 0 && m_cyc >= 3 && m_cyc <= m_n + 2;
            exp_rd = m_active && m_n > 0 && m_cyc >= 1 && m_cyc <= m_n;
            exp_u  = exp_v ? m_unsat(rom[m_cyc-3], m_assign) : 1'b0;
            chk("valid", clause_valid, exp_v);
            chk("rd", clause_rd, exp_rd);
            chk("unsat", clause_unsat, exp_u);
            chk("sclr", sticky_clear, m_active && m_cyc == 1);
            chk("done", done, m_active && m_cyc == m_end);
            chk("busy", busy, m_active && m_n > 0 && m_cyc <= m_n + 2);
            if (exp_v) chk("idx", clause_idx, m_cyc - 3);
            if (exp_rd) chk("addr", clause_addr, m_cyc - 1);
            rel = tcyc - start_tc + 1;
            if (clause_rd) rd_cnt++;
            if (clause_valid) begin
                valid_cnt++;
                q_unsat.push_back(clause_unsat);
                q_idx.push_back(int'(clause_idx));
                if (fv_rel < 0) fv_rel = rel;
            end
            if (sticky_clear && sc_rel < 0) sc_rel = rel;
            if (done) begin
                done_cnt++;
                seen_done = 1'b1;
                if (done_rel < 0) done_rel = rel;
            end
        end
    end

    task automatic start_pass(input int n, input logic [15:0] a);
        @(negedge clk);
        clear_mon();
        num_clauses = 6'(n);
        assignment  = a;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start_tc = tcyc;
        start    = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (!seen_done && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_finished"}, seen_done, 1'b1);
        @(negedge clk);
    endtask

    task automatic chk_unsat(input string nm, input int n, input logic [31:0] pat);
        chk({nm, "_count"}, valid_cnt, n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_u%0d", nm, i), q_unsat[i], pat[i]);
            chk($sformatf("%s_i%0d", nm, i), q_idx[i], i);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_rd"}, clause_rd, 0);
        chk({nm, "_valid"}, clause_valid, 0);
        chk({nm, "_unsat"}, clause_unsat, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_sclr"}, sticky_clear, 0);
        chk({nm, "_addr"}, clause_addr, 0);
        chk({nm, "_idx"}, clause_idx, 0);
    endtask

    initial begin
        start = 1'b0;
        num_clauses = '0;
        assignment = '0;
        for (int i = 0; i < 32; i++) rom[i] = '0;
        clear_mon();
        start_tc = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst");
        reset = 1'b0;

        // {x0}, {~x1}, {x0 | x2} under x0=1: all satisfied.
        rom[0] = {18'd0, lit(0, 0)};
        rom[1] = {18'd0, lit(1, 1)};
        rom[2] = {12'd0, lit(0, 2), lit(0, 0)};
        start_pass(3, 16'h0001);
        wait_done("p1");
        chk_unsat("p1", 3, 32'b000);
        chk("p1_sclr_cyc", sc_rel, 1);
        chk("p1_first_valid_cyc", fv_rel, 3);
        chk("p1_done_cyc", done_rel, 6);
        chk("p1_sticky", sticky, 0);

        // {x3} false and an empty clause: both unsat.
        rom[0] = {18'd0, lit(0, 3)};
        rom[1] = '0;
        start_pass(2, 16'h0000);
        wait_done("p2");
        chk_unsat("p2", 2, 32'b11);
        chk("p2_done_cyc", done_rel, 5);
        chk("p2_sticky", sticky, 1);

        start_pass(0, 16'hFFFF);
        wait_done("p3");
        chk("p3_sclr_cyc", sc_rel, 1);
        chk("p3_done_cyc", done_rel, 1);
        chk("p3_rd_cnt", rd_cnt, 0);
        chk("p3_valid_cnt", valid_cnt, 0);

        // Latched 0x00F0 gives 0,1,1,1; the ignored 0x000F would give 1,0,0,0.
        rom[0] = {18'd0, lit(0, 4)};
        rom[1] = {18'd0, lit(0, 0)};
        rom[2] = {12'd0, lit(0, 1), lit(1, 5)};
        rom[3] = {lit(0, 8), lit(1, 6), lit(0, 9), lit(1, 7)};
        start_pass(4, 16'h00F0);
        @(posedge clk);
        #1;
        start = 1'b1;
        assignment = 16'h000F;
        num_clauses = 6'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("p4");
        chk_unsat("p4", 4, 32'b1110);
        chk("p4_done_cnt", done_cnt, 1);
        chk("p4_done_cyc", done_rel, 7);

        // Request above ROM depth saturates to 32 clauses.
        for (int i = 0; i < 32; i++) rom[i] = {18'd0, lit(bit'((i / 16) % 2), i % 16)};
        start_pass(40, 16'h5555);
        wait_done("p5");
        chk("p5_valid_cnt", valid_cnt, 32);
        chk("p5_last_idx", q_idx[31], 31);
        chk("p5_done_cyc", done_rel, 35);

        start_pass(8, 16'h1234);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("abort");
        #5;
        reset = 1'b0;
        clear_mon();
        repeat (12) @(negedge clk);
        chk("abort_valid_cnt", valid_cnt, 0);
        chk("abort_done_cnt", done_cnt, 0);

        rom[0] = {18'd0, lit(1, 2)};
        start_pass(1, 16'h0004);
        wait_done("p6");
        chk_unsat("p6", 1, 32'b1);
        chk("p6_done_cnt", done_cnt, 1);
        chk("p6_done_cyc", done_rel, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
